// File: rtl/anc_stream_driver.sv
// anc_stream_driver: paces FIFO'd {e,x,a,u} frames into the ANC core per sample_tick and captures its output.
module anc_stream_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_e,
    input  logic [15:0] wr_x,
    input  logic [15:0] wr_a,
    input  logic [15:0] wr_u,
    input  logic        sample_tick,
    output logic        in_valid,
    input  logic        controller_ready,
    output logic [15:0] e_in,
    output logic [15:0] x_in,
    output logic [15:0] a_in,
    output logic [15:0] u_in,
    input  logic [15:0] out_sample,
    input  logic        out_valid,
    output logic [15:0] rd_sample,
    output logic        rd_valid,
    output logic        underrun,
    output logic        overrun,
    output logic        timeout,
    output logic        spurious,
    output logic [15:0] frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_OUT} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW:0]   wp, rp;
    logic [TW-1:0] timer;
    logic          empty, full, push, pop;

    assign empty    = wp == rp;
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = state == IDLE && sample_tick && !empty;

    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= {wr_e, wr_x, wr_a, wr_u};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wp        <= '0;
            rp        <= '0;
            timer     <= '0;
            in_valid  <= 1'b0;
            e_in      <= '0;
            x_in      <= '0;
            a_in      <= '0;
            u_in      <= '0;
            rd_sample <= '0;
            rd_valid  <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            spurious  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            underrun <= state == IDLE && sample_tick && empty;
            overrun  <= state != IDLE && sample_tick;
            spurious <= state != WAIT_OUT && out_valid;
            rd_valid <= state == WAIT_OUT && out_valid;
            timeout  <= state == WAIT_OUT && !out_valid && timer == TW'(TIMEOUT - 1);
            if (push) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            case (state)
                IDLE: if (pop) begin
                    {e_in, x_in, a_in, u_in} <= mem[rp[AW-1:0]];
                    in_valid <= 1'b1;
                    state    <= LAUNCH;
                end
                LAUNCH: if (controller_ready) begin
                    in_valid  <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                    timer     <= '0;
                    state     <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (out_valid) begin
                        rd_sample <= out_sample;
                        state     <= IDLE;
                    end else if (timer == TW'(TIMEOUT - 1))
                        state <= IDLE;
                    else
                        timer <= timer + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_anc_stream_driver.sv
// tb_anc_stream_driver: directed literal checks plus randomized run against a queue-based reference model.
module tb_anc_stream_driver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 0, rst, wr_valid, wr_ready, sample_tick, in_valid, controller_ready;
    logic [15:0] wr_e, wr_x, wr_a, wr_u, e_in, x_in, a_in, u_in, out_sample, rd_sample, frame_cnt;
    logic        out_valid, rd_valid, underrun, overrun, timeout, spurious;

    anc_stream_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_e(wr_e), .wr_x(wr_x), .wr_a(wr_a), .wr_u(wr_u),
        .sample_tick(sample_tick), .in_valid(in_valid), .controller_ready(controller_ready),
        .e_in(e_in), .x_in(x_in), .a_in(a_in), .u_in(u_in),
        .out_sample(out_sample), .out_valid(out_valid), .rd_sample(rd_sample), .rd_valid(rd_valid),
        .underrun(underrun), .overrun(overrun), .timeout(timeout), .spurious(spurious),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: frames in a queue, the core transaction tracked as
    // "offered" / "awaiting output until an absolute deadline cycle".
    logic [63:0] q[$];
    logic [63:0] m_frame;
    logic [15:0] m_rd, m_cnt;
    bit          m_offer, m_await, m_rdv, m_under, m_over, m_to, m_spur, started;
    bit          offer0, await0, full0;
    int          cyc = 0, m_deadline;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            {m_offer, m_await, m_rdv, m_under, m_over, m_to, m_spur} = '0;
            m_rd    = 0;
            m_cnt   = 0;
            started = 1;
        end else if (started) begin
            offer0 = m_offer;
            await0 = m_await;
            full0  = q.size() == DEPTH;
            {m_rdv, m_under, m_over, m_to, m_spur} = '0;
            if (sample_tick) begin
                if (offer0 || await0) m_over = 1;
                else if (q.size() == 0) m_under = 1;
                else begin
                    m_frame = q.pop_front();
                    m_offer = 1;
                end
            end
            if (offer0 && controller_ready) begin
                m_offer    = 0;
                m_await    = 1;
                m_deadline = cyc + TIMEOUT;
                m_cnt      = m_cnt + 16'd1;
            end
            if (out_valid) begin
                if (await0) begin
                    m_rd    = out_sample;
                    m_rdv   = 1;
                    m_await = 0;
                end else m_spur = 1;
            end else if (await0 && cyc == m_deadline) begin
                m_to    = 1;
                m_await = 0;
            end
            if (wr_valid && !full0) q.push_back({wr_e, wr_x, wr_a, wr_u});
        end
        cyc++;
    end

    always @(negedge clk) if (started) begin
        chk("m_in_valid", in_valid, m_offer);
        if (in_valid) chk("m_frame", {e_in, x_in, a_in, u_in}, m_frame);
        chk("m_wr_ready", wr_ready, q.size() < DEPTH);
        chk("m_rd_sample", rd_sample, m_rd);
        chk("m_rd_valid", rd_valid, m_rdv);
        chk("m_underrun", underrun, m_under);
        chk("m_overrun", overrun, m_over);
        chk("m_timeout", timeout, m_to);
        chk("m_spurious", spurious, m_spur);
        chk("m_frame_cnt", frame_cnt, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [63:0] f);
        {wr_e, wr_x, wr_a, wr_u} = f;
    endtask

    initial begin
        {wr_valid, sample_tick, controller_ready, out_valid} = '0;
        {wr_e, wr_x, wr_a, wr_u, out_sample} = '0;
        rst = 1;
        step();
        step();
        rst = 0;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_rd_sample", rd_sample, 0);

        set_frame(64'h1234_8000_7FFF_0010);
        wr_valid = 1; step(); wr_valid = 0;
        sample_tick = 1; step(); sample_tick = 0;
        chk("basic_launch", in_valid, 1);
        chk("basic_fields", {e_in, x_in, a_in, u_in}, 64'h1234_8000_7FFF_0010);
        step(); step();
        chk("basic_hold_iv", in_valid, 1);
        chk("basic_hold_fields", {e_in, x_in, a_in, u_in}, 64'h1234_8000_7FFF_0010);
        controller_ready = 1; step(); controller_ready = 0;
        chk("basic_accept_iv", in_valid, 0);
        chk("basic_frame_cnt", frame_cnt, 1);
        repeat (3) step();
        out_sample = 16'hBEEF; out_valid = 1; step(); out_valid = 0;
        chk("basic_rd_valid", rd_valid, 1);
        chk("basic_rd_sample", rd_sample, 16'hBEEF);
        step();
        chk("basic_rd_pulse", rd_valid, 0);

        sample_tick = 1; step(); sample_tick = 0;
        chk("underrun", underrun, 1);
        chk("underrun_iv", in_valid, 0);
        step();
        chk("underrun_pulse", underrun, 0);
        chk("underrun_cnt", frame_cnt, 1);
        set_frame(64'h000A_000B_000C_000D);
        wr_valid = 1; sample_tick = 1; step(); wr_valid = 0; sample_tick = 0;
        chk("underrun_push", underrun, 1);
        chk("underrun_push_iv", in_valid, 0);

        controller_ready = 1; sample_tick = 1; step(); sample_tick = 0;
        chk("to_launch", in_valid, 1);
        step(); controller_ready = 0;
        chk("to_accept_cnt", frame_cnt, 2);
        sample_tick = 1; step(); sample_tick = 0;
        chk("overrun", overrun, 1);
        repeat (6) step();
        chk("to_early", timeout, 0);
        step();
        chk("timeout", timeout, 1);
        chk("to_idle_iv", in_valid, 0);
        out_sample = 16'h5555; out_valid = 1; step(); out_valid = 0;
        chk("late_spurious", spurious, 1);
        chk("late_rd_valid", rd_valid, 0);
        chk("late_rd_sample", rd_sample, 16'hBEEF);

        for (int i = 0; i < 5; i++) begin
            set_frame({16'(16'h0100 + i), 16'(16'h0200 + i), 16'(16'h0300 + i), 16'(16'h0400 + i)});
            wr_valid = 1; step();
        end
        wr_valid = 0;
        chk("full_wr_ready", wr_ready, 0);
        for (int i = 0; i < 4; i++) begin
            sample_tick = 1; controller_ready = 1; step(); sample_tick = 0;
            chk("full_order", {e_in, x_in, a_in, u_in},
                {16'(16'h0100 + i), 16'(16'h0200 + i), 16'(16'h0300 + i), 16'(16'h0400 + i)});
            chk("full_pop_ready", wr_ready, 1);
            step(); controller_ready = 0;
            out_valid = 1; step(); out_valid = 0;
        end
        chk("full_frame_cnt", frame_cnt, 6);

        for (int i = 0; i < 2; i++) begin
            set_frame(64'hCAFE_0000_0000_0000 + 64'(i));
            wr_valid = 1; step();
        end
        wr_valid = 0;
        sample_tick = 1; step(); sample_tick = 0;
        chk("rst_mid_iv", in_valid, 1);
        rst = 1; step(); rst = 0;
        chk("rst_mid_iv0", in_valid, 0);
        chk("rst_mid_cnt", frame_cnt, 0);
        chk("rst_mid_wr_ready", wr_ready, 1);
        chk("rst_mid_rd_sample", rd_sample, 0);
        sample_tick = 1; step(); sample_tick = 0;
        chk("rst_mid_underrun", underrun, 1);

        repeat (4000) begin
            rst              = $urandom_range(0, 399) == 0;
            wr_valid         = $urandom_range(0, 1) == 1;
            sample_tick      = $urandom_range(0, 5) == 0;
            controller_ready = $urandom_range(0, 1) == 1;
            out_valid        = $urandom_range(0, 3) == 0;
            out_sample       = 16'($urandom);
            set_frame({32'($urandom), 32'($urandom)});
            step();
        end
        {rst, wr_valid, sample_tick, controller_ready, out_valid} = '0;
        step();
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
